// File: rtl/tinyacc_pkg.sv
// Shared definitions for the tinyacc instruction front end: opcodes,
// instruction field positions and the dispatcher state encoding.
package tinyacc_pkg;

    localparam int INSTR_W = 105;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_CFG = 4'h1;
    localparam logic [3:0] OP_RUN = 4'h2;

    // Low bit of each field; opcode is 4 bits wide, the others 16.
    localparam int OP_LO    = 101;
    localparam int A_LO     = 85;
    localparam int B_LO     = 69;
    localparam int O_LO     = 53;
    localparam int M_LO     = 37;
    localparam int K_LO     = 21;
    localparam int N_LO     = 5;
    localparam int LAST_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } disp_state_t;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[OP_LO +: 4];
    endfunction

    function automatic logic [15:0] instr_field16(input logic [INSTR_W-1:0] w, input int lo);
        return w[lo +: 16];
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue between the host handshake and the dispatcher FSM.
// Head word is presented combinationally on rdata while not empty.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 105
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int         PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// Host instruction intake and dispatch to the compute engine: one ack per
// host valid, queued decode of NOP/CFG/RUN, start/done handshake with engine.
`ifndef WORD_ADDR_BITS
`define WORD_ADDR_BITS 16
`endif

module instr_dispatch
    import tinyacc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = `WORD_ADDR_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [AW-1:0]      data_total,
    output logic               ack,
    output logic               exe_start,
    output logic [AW-1:0]      exe_a_base,
    output logic [AW-1:0]      exe_b_base,
    output logic [AW-1:0]      exe_o_base,
    output logic [15:0]        exe_m,
    output logic [15:0]        exe_k,
    output logic [15:0]        exe_n,
    output logic [AW-1:0]      exe_len,
    input  logic               exe_done,
    output logic               done,
    output logic               err
);

    disp_state_t        state;
    disp_state_t        state_nx;
    logic               armed;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_head;
    logic [INSTR_W-1:0] cur_instr;
    logic [3:0]         cur_op;
    logic               pop;
    logic               cfg_load;
    logic               err_set;
    logic               start_set;
    logic               done_set;
    logic [AW-1:0]      cfg_a;
    logic [AW-1:0]      cfg_b;
    logic [AW-1:0]      cfg_o;
    logic [15:0]        cfg_m;
    logic [15:0]        cfg_k;
    logic [15:0]        cfg_n;
    logic               unused_rsvd;

    assign accept      = instr_valid && !fifo_full && armed;
    assign cur_op      = instr_opcode(cur_instr);
    assign unused_rsvd = ^cur_instr[3:0];

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (instr),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Host handshake: ack is registered, so instr_valid never reaches it combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b1;
            ack   <= 1'b0;
        end else begin
            ack <= accept;
            if (accept) begin
                armed <= 1'b0;
            end else if (!instr_valid) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        cfg_load  = 1'b0;
        err_set   = 1'b0;
        start_set = 1'b0;
        done_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cur_op)
                    OP_NOP:  state_nx = ST_IDLE;
                    OP_CFG: begin
                        cfg_load = 1'b1;
                        state_nx = ST_IDLE;
                    end
                    OP_RUN:  state_nx = ST_ISSUE;
                    default: begin
                        err_set  = 1'b1;
                        state_nx = ST_IDLE;
                    end
                endcase
            end
            ST_ISSUE: begin
                start_set = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                if (exe_done) begin
                    done_set = cur_instr[LAST_BIT];
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_instr <= '0;
            cfg_a     <= '0;
            cfg_b     <= '0;
            cfg_o     <= '0;
            cfg_m     <= '0;
            cfg_k     <= '0;
            cfg_n     <= '0;
            exe_start <= 1'b0;
            exe_len   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (pop) cur_instr <= fifo_head;
            if (cfg_load) begin
                cfg_a <= AW'(instr_field16(cur_instr, A_LO));
                cfg_b <= AW'(instr_field16(cur_instr, B_LO));
                cfg_o <= AW'(instr_field16(cur_instr, O_LO));
                cfg_m <= instr_field16(cur_instr, M_LO);
                cfg_k <= instr_field16(cur_instr, K_LO);
                cfg_n <= instr_field16(cur_instr, N_LO);
            end
            exe_start <= start_set;
            if (start_set) exe_len <= data_total;
            if (err_set)   err <= 1'b1;
            // A completing last RUN wins over a same-cycle accept.
            if (done_set)    done <= 1'b1;
            else if (accept) done <= 1'b0;
        end
    end

    // Config can only change in DECODE, so these hold steady across ISSUE/WAIT.
    assign exe_a_base = cfg_a;
    assign exe_b_base = cfg_b;
    assign exe_o_base = cfg_o;
    assign exe_m      = cfg_m;
    assign exe_k      = cfg_k;
    assign exe_n      = cfg_n;

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, instruction FIFO entries (power of two, >=2).
REQ-002 Parameter AW, default `WORD_ADDR_BITS, global-buffer word-address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid  in  1  host instruction present (level; held until ack seen).
REQ-006 instr  in  105  host instruction word.
REQ-007 data_total  in  AW  output words per RUN; sampled at RUN issue.
REQ-008 ack  out  1  one-cycle accept pulse for instr.
REQ-009 exe_start  out  1  one-cycle start pulse to compute engine.
REQ-010 exe_a_base, exe_b_base, exe_o_base  out  AW each  buffer base addresses.
REQ-011 exe_m, exe_k, exe_n  out  16 each  matrix dims.
REQ-012 exe_len  out  AW  latched data_total.
REQ-013 exe_done  in  1  one-cycle engine completion pulse.
REQ-014 done  out  1  sticky program-complete flag.
REQ-015 err  out  1  sticky illegal-opcode / overflow flag.

Function
REQ-016 Instruction fields: [104:101] opcode, [100:85] A base, [84:69] B base, [68:53] O base, [52:37] M, [36:21] K, [20:5] N, [4] last, [3:0] reserved (ignored).
REQ-017 Opcodes: 4'h0 NOP, 4'h1 CFG, 4'h2 RUN; all others illegal.
REQ-018 Accept when instr_valid=1, FIFO not full, and armed; ack=1 the following cycle, instr pushed same edge.
REQ-019 After an accept, disarmed until instr_valid sampled 0; exactly one ack per host valid assertion.
REQ-020 FIFO full: no ack, instr_valid held off without loss.
REQ-021 FSM states IDLE, DECODE, ISSUE, WAIT; IDLE->DECODE when FIFO non-empty (pop same edge).
REQ-022 DECODE: NOP->IDLE; CFG->latch A/B/O bases and M/K/N into config regs, ->IDLE; RUN->ISSUE; illegal->set err, ->IDLE.
REQ-023 ISSUE: exe_start=1 for exactly one cycle, exe_len<=data_total, ->WAIT.
REQ-024 exe_* address/dim outputs reflect config regs, stable from ISSUE until WAIT exit.
REQ-025 WAIT: on exe_done ->IDLE; exe_done outside WAIT ignored.
REQ-026 done set on exe_done in WAIT when that RUN had last=1; cleared on next ack.
REQ-027 Simultaneous accept and pop: both occur; count unchanged; pointers wrap modulo DEPTH.
REQ-028 RUN with no prior CFG uses reset (zero) config values.
REQ-029 Latency: instruction accepted into empty FIFO in IDLE -> exe_start 3 cycles after ack.

Reset
REQ-030 rst=0 asynchronously forces: ack=0, exe_start=0, done=0, err=0, all exe_* =0, FIFO empty, FSM IDLE, armed=1.
REQ-031 Reset mid-WAIT abandons the RUN; later exe_done pulses ignored until a new ISSUE.
REQ-032 First accept possible on the first rising edge after rst deasserts.

Structure
REQ-033 Opcode values, field bit positions, and FSM state encoding in shared package tinyacc_pkg.
REQ-034 FIFO as one sub-module instr_fifo (DEPTH x 105, push/pop/full/empty); decode and FSM in instr_dispatch.
REQ-035 Target 150-300 lines RTL; no combinational path from instr_valid to ack.

Verification
REQ-036 CFG(A=0x0010,B=0x0020,O=0x0030,M=K=N=4) then RUN(last=1), data_total=16 -> one ack each, exe_start once with those values and exe_len=16; exe_done -> done=1.
REQ-037 instr_valid held high 10 cycles after ack -> exactly one ack, one FIFO entry.
REQ-038 Engine stalled in WAIT, 5 RUNs pushed, DEPTH=4 -> 4 acks, 5th withheld until a pop, then acked; no instruction lost.
REQ-039 Opcode 4'hF -> err=1 sticky, no exe_start; following RUN still issues.
REQ-040 rst=0 during WAIT, then exe_done pulse -> all outputs zero, no done, FSM IDLE.
REQ-041 RUN with last=0 then RUN with last=1 -> done rises only after second exe_done; new ack clears done.
